// File: rtl/soc_noc_lsu_read_master.sv
// Tile-side LSU read initiator: turns a local word-read request into a READREQ
// packet on the NoC, then streams the matching response words back to the requester.
module soc_noc_lsu_read_master #(
    parameter int FLIT_WIDTH = 32,
    parameter int MAX_BURST  = 8,
    parameter int LEN_WIDTH  = 5,
    parameter int SRC_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [4:0]            req_dest,
    input  logic [FLIT_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic [FLIT_WIDTH-1:0] noc_out_flit,
    output logic                  noc_out_last,
    output logic                  noc_out_valid,
    input  logic                  noc_out_ready,
    input  logic [FLIT_WIDTH-1:0] noc_in_flit,
    input  logic                  noc_in_last,
    input  logic                  noc_in_valid,
    output logic                  noc_in_ready,
    output logic [FLIT_WIDTH-1:0] rsp_data,
    output logic                  rsp_valid,
    output logic                  rsp_last,
    input  logic                  rsp_ready,
    output logic                  rsp_err
);
    typedef enum logic [2:0] {IDLE, HDR, ADDR, LEN, WAIT_HDR, DATA, DRAIN} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [FLIT_WIDTH-1:0]  addr_q;
    logic                   drain_err;

    logic [LEN_WIDTH-1:0]   req_len_n;
    logic [FLIT_WIDTH-1:0]  hdr_flit;
    logic                   out_hs;
    logic                   in_hs;
    logic                   hdr_match;
    logic                   last_word;

    always_comb begin
        req_len_n = req_len;
        if (req_len == '0)
            req_len_n = LEN_WIDTH'(1);
        else if (req_len > LEN_WIDTH'(MAX_BURST))
            req_len_n = LEN_WIDTH'(MAX_BURST);
    end

    assign hdr_flit  = {req_dest, 3'h2, 5'(SRC_ID), 3'h0, (req_len_n != LEN_WIDTH'(1)), 15'b0};
    assign out_hs    = noc_out_valid && noc_out_ready;
    assign in_hs     = noc_in_valid && noc_in_ready;
    assign hdr_match = (noc_in_flit[31:27] == 5'(SRC_ID)) && (noc_in_flit[26:24] == 3'h2);
    assign last_word = (cnt == len_q - LEN_WIDTH'(1));

    // Response side is flow-through; only the request flits are registered.
    always_comb begin
        req_ready    = rst_n && (state == IDLE);
        noc_in_ready = 1'b0;
        case (state)
            WAIT_HDR, DRAIN: noc_in_ready = 1'b1;
            DATA:            noc_in_ready = rsp_ready;
            default:         noc_in_ready = 1'b0;
        endcase
        rsp_data  = noc_in_flit;
        rsp_valid = (state == DATA) && noc_in_valid;
        rsp_last  = (state == DATA) && (last_word || noc_in_last);
        rsp_err   = ((state == WAIT_HDR) && noc_in_valid && hdr_match && noc_in_last) ||
                    ((state == DATA) && in_hs && noc_in_last && !last_word) ||
                    ((state == DRAIN) && noc_in_valid && noc_in_last && drain_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            len_q         <= '0;
            cnt           <= '0;
            addr_q        <= '0;
            drain_err     <= 1'b0;
            noc_out_flit  <= '0;
            noc_out_last  <= 1'b0;
            noc_out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q        <= req_addr;
                    len_q         <= req_len_n;
                    noc_out_flit  <= hdr_flit;
                    noc_out_last  <= 1'b0;
                    noc_out_valid <= 1'b1;
                    state         <= HDR;
                end
                HDR: if (out_hs) begin
                    noc_out_flit <= addr_q;
                    noc_out_last <= (len_q == LEN_WIDTH'(1));
                    state        <= ADDR;
                end
                ADDR: if (out_hs) begin
                    if (len_q == LEN_WIDTH'(1)) begin
                        noc_out_flit  <= '0;
                        noc_out_last  <= 1'b0;
                        noc_out_valid <= 1'b0;
                        state         <= WAIT_HDR;
                    end else begin
                        noc_out_flit <= {{(FLIT_WIDTH-LEN_WIDTH){1'b0}}, len_q};
                        noc_out_last <= 1'b1;
                        state        <= LEN;
                    end
                end
                LEN: if (out_hs) begin
                    noc_out_flit  <= '0;
                    noc_out_last  <= 1'b0;
                    noc_out_valid <= 1'b0;
                    state         <= WAIT_HDR;
                end
                WAIT_HDR: if (noc_in_valid) begin
                    if (hdr_match) begin
                        cnt   <= '0;
                        state <= noc_in_last ? IDLE : DATA;
                    end else if (!noc_in_last) begin
                        drain_err <= 1'b0;
                        state     <= DRAIN;
                    end
                end
                DATA: if (in_hs) begin
                    cnt <= cnt + LEN_WIDTH'(1);
                    if (noc_in_last) begin
                        state <= IDLE;
                    end else if (last_word) begin
                        // Response longer than requested: discard the tail, flag at its end.
                        drain_err <= 1'b1;
                        state     <= DRAIN;
                    end
                end
                DRAIN: if (noc_in_valid && noc_in_last)
                    state <= drain_err ? IDLE : WAIT_HDR;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_noc_lsu_read_master.sv
// Directed bench for soc_noc_lsu_read_master with SRC_ID=3, MAX_BURST=8.
module tb_soc_noc_lsu_read_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_dest = '0;
    logic [31:0] req_addr = '0;
    logic [4:0]  req_len = '0;
    logic [31:0] noc_out_flit;
    logic        noc_out_last, noc_out_valid;
    logic        noc_out_ready = 1'b0;
    logic [31:0] noc_in_flit = '0;
    logic        noc_in_last = 1'b0, noc_in_valid = 1'b0;
    logic        noc_in_ready;
    logic [31:0] rsp_data;
    logic        rsp_valid, rsp_last, rsp_err;
    logic        rsp_ready = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] RSP_HDR = 32'h1A28_0000;
    localparam logic [31:0] FOREIGN = 32'h3A28_0000;

    soc_noc_lsu_read_master #(.FLIT_WIDTH(32), .MAX_BURST(8), .LEN_WIDTH(5), .SRC_ID(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
        .req_addr(req_addr), .req_len(req_len),
        .noc_out_flit(noc_out_flit), .noc_out_last(noc_out_last),
        .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
        .noc_in_flit(noc_in_flit), .noc_in_last(noc_in_last),
        .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_last(rsp_last),
        .rsp_ready(rsp_ready), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_in(input logic v, input logic [31:0] f, input logic l);
        noc_in_valid = v;
        noc_in_flit  = f;
        noc_in_last  = l;
    endtask

    // Issues a request with the output always ready; returns in the cycle the DUT
    // reaches WAIT_HDR (noc_out_valid low again).
    task automatic send_req(input logic [4:0] d, input logic [31:0] a, input logic [4:0] l);
        int n;
        req_valid = 1'b1; req_dest = d; req_addr = a; req_len = l;
        noc_out_ready = 1'b1;
        n = 0;
        do begin
            step();
            req_valid = 1'b0;
            n++;
        end while (noc_out_valid && n < 10);
        #1 chk("send_req_done", {31'b0, noc_out_valid}, 32'd0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, noc_out_valid}, 32'd0);
        chk("rst_out_flit", noc_out_flit, 32'd0);
        chk("rst_in_ready", {31'b0, noc_in_ready}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        step(); rst_n = 1'b1;
        #1 chk("idle_req_ready", {31'b0, req_ready}, 32'd1);

        // single word read
        step();
        req_valid = 1'b1; req_dest = 5'd5; req_addr = 32'h1000; req_len = 5'd1; noc_out_ready = 1'b1;
        step(); req_valid = 1'b0;
        #1 chk("t1_hdr", noc_out_flit, 32'h2A18_0000);
        chk("t1_hdr_last", {31'b0, noc_out_last}, 32'd0);
        chk("t1_busy", {31'b0, req_ready}, 32'd0);
        step();
        #1 chk("t1_addr", noc_out_flit, 32'h0000_1000);
        chk("t1_addr_last", {31'b0, noc_out_last}, 32'd1);
        step();
        drive_in(1'b1, RSP_HDR, 1'b0);
        #1 chk("t1_out_idle", {31'b0, noc_out_valid}, 32'd0);
        chk("t1_in_ready", {31'b0, noc_in_ready}, 32'd1);
        step();
        drive_in(1'b1, 32'hDEAD_BEEF, 1'b1); rsp_ready = 1'b1;
        #1 chk("t1_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("t1_rsp_data", rsp_data, 32'hDEAD_BEEF);
        chk("t1_rsp_last", {31'b0, rsp_last}, 32'd1);
        chk("t1_rsp_err", {31'b0, rsp_err}, 32'd0);
        step();
        drive_in(1'b0, 32'h0, 1'b0);
        #1 chk("t1_back_idle", {31'b0, req_ready}, 32'd1);

        // burst of 4 with output stalls, then response with requester stalls
        req_valid = 1'b1; req_addr = 32'h2000; req_len = 5'd4; noc_out_ready = 1'b0;
        step(); req_valid = 1'b0;
        #1 chk("t2_hdr", noc_out_flit, 32'h2A18_8000);
        step(); noc_out_ready = 1'b1;
        #1 chk("t2_hdr_stall", noc_out_flit, 32'h2A18_8000);
        chk("t2_hdr_valid", {31'b0, noc_out_valid}, 32'd1);
        step(); noc_out_ready = 1'b0;
        #1 chk("t2_addr", noc_out_flit, 32'h2000);
        chk("t2_addr_last", {31'b0, noc_out_last}, 32'd0);
        step(); noc_out_ready = 1'b1;
        #1 chk("t2_addr_stall", noc_out_flit, 32'h2000);
        step(); noc_out_ready = 1'b0;
        #1 chk("t2_len", noc_out_flit, 32'd4);
        chk("t2_len_last", {31'b0, noc_out_last}, 32'd1);
        step(); noc_out_ready = 1'b1;
        #1 chk("t2_len_stall", noc_out_flit, 32'd4);
        chk("t2_len_stall_last", {31'b0, noc_out_last}, 32'd1);
        step();
        drive_in(1'b1, RSP_HDR, 1'b0);
        #1 chk("t2_out_done", {31'b0, noc_out_valid}, 32'd0);
        step();
        drive_in(1'b1, 32'h1111_0000, 1'b0); rsp_ready = 1'b1;
        #1 chk("t2_w0", rsp_data, 32'h1111_0000);
        chk("t2_w0_last", {31'b0, rsp_last}, 32'd0);
        step();
        drive_in(1'b1, 32'h1111_0001, 1'b0); rsp_ready = 1'b0;
        #1 chk("t2_stall1_ready", {31'b0, noc_in_ready}, 32'd0);
        step();
        #1 chk("t2_stall2_ready", {31'b0, noc_in_ready}, 32'd0);
        chk("t2_stall2_valid", {31'b0, rsp_valid}, 32'd1);
        step(); rsp_ready = 1'b1;
        #1 chk("t2_w1", rsp_data, 32'h1111_0001);
        chk("t2_w1_ready", {31'b0, noc_in_ready}, 32'd1);
        chk("t2_w1_last", {31'b0, rsp_last}, 32'd0);
        step();
        drive_in(1'b1, 32'h1111_0002, 1'b0);
        #1 chk("t2_w2", rsp_data, 32'h1111_0002);
        chk("t2_w2_last", {31'b0, rsp_last}, 32'd0);
        step();
        drive_in(1'b1, 32'h1111_0003, 1'b1);
        #1 chk("t2_w3", rsp_data, 32'h1111_0003);
        chk("t2_w3_last", {31'b0, rsp_last}, 32'd1);
        chk("t2_w3_err", {31'b0, rsp_err}, 32'd0);
        step();
        drive_in(1'b0, 32'h0, 1'b0);
        #1 chk("t2_back_idle", {31'b0, req_ready}, 32'd1);

        // len 0 becomes a single; header-only response flags an error
        req_valid = 1'b1; req_addr = 32'h3000; req_len = 5'd0;
        step(); req_valid = 1'b0;
        #1 chk("t3_hdr_single", noc_out_flit, 32'h2A18_0000);
        step();
        #1 chk("t3_addr_last", {31'b0, noc_out_last}, 32'd1);
        step();
        drive_in(1'b1, RSP_HDR, 1'b1);
        #1 chk("t3_hdr_only_err", {31'b0, rsp_err}, 32'd1);
        step();
        drive_in(1'b0, 32'h0, 1'b0);
        #1 chk("t3_back_idle", {31'b0, req_ready}, 32'd1);

        // len 20 saturates to 8
        req_valid = 1'b1; req_addr = 32'h3100; req_len = 5'd20;
        step(); req_valid = 1'b0;
        #1 chk("t4_hdr_burst", noc_out_flit, 32'h2A18_8000);
        step(); step();
        #1 chk("t4_len_sat", noc_out_flit, 32'd8);
        chk("t4_len_last", {31'b0, noc_out_last}, 32'd1);
        step();
        // foreign packet is drained silently
        drive_in(1'b1, FOREIGN, 1'b0);
        #1 chk("t4_f0_err", {31'b0, rsp_err}, 32'd0);
        step();
        drive_in(1'b1, 32'hAAAA_0001, 1'b0);
        #1 chk("t4_f1_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t4_f1_ready", {31'b0, noc_in_ready}, 32'd1);
        step();
        drive_in(1'b1, 32'hAAAA_0002, 1'b1);
        #1 chk("t4_f2_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t4_f2_err", {31'b0, rsp_err}, 32'd0);
        step();
        drive_in(1'b1, RSP_HDR, 1'b0);
        #1 chk("t4_rhdr_ready", {31'b0, noc_in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            drive_in(1'b1, 32'h5500_0000 + i, i == 7);
            #1 chk("t4_word", rsp_data, 32'h5500_0000 + i);
            chk("t4_word_last", {31'b0, rsp_last}, {31'b0, i == 7});
            chk("t4_word_valid", {31'b0, rsp_valid}, 32'd1);
        end
        step();
        drive_in(1'b0, 32'h0, 1'b0);
        #1 chk("t4_back_idle", {31'b0, req_ready}, 32'd1);

        // short response: 2 of 4 words
        send_req(5'd5, 32'h5000, 5'd4);
        drive_in(1'b1, RSP_HDR, 1'b0);
        step();
        drive_in(1'b1, 32'h6600_0000, 1'b0);
        #1 chk("t5_w0_last", {31'b0, rsp_last}, 32'd0);
        chk("t5_w0_err", {31'b0, rsp_err}, 32'd0);
        step();
        drive_in(1'b1, 32'h6600_0001, 1'b1);
        #1 chk("t5_w1_last", {31'b0, rsp_last}, 32'd1);
        chk("t5_w1_err", {31'b0, rsp_err}, 32'd1);
        step();
        drive_in(1'b0, 32'h0, 1'b0);
        #1 chk("t5_back_idle", {31'b0, req_ready}, 32'd1);

        // long response: 6 words for a 4-word request
        send_req(5'd5, 32'h6000, 5'd4);
        drive_in(1'b1, RSP_HDR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            drive_in(1'b1, 32'h7700_0000 + i, 1'b0);
            #1 chk("t6_word", rsp_data, 32'h7700_0000 + i);
            chk("t6_word_last", {31'b0, rsp_last}, {31'b0, i == 3});
            chk("t6_word_err", {31'b0, rsp_err}, 32'd0);
        end
        step();
        drive_in(1'b1, 32'h7700_0004, 1'b0);
        #1 chk("t6_w4_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t6_w4_ready", {31'b0, noc_in_ready}, 32'd1);
        chk("t6_w4_err", {31'b0, rsp_err}, 32'd0);
        step();
        drive_in(1'b1, 32'h7700_0005, 1'b1);
        #1 chk("t6_w5_valid", {31'b0, rsp_valid}, 32'd0);
        chk("t6_w5_err", {31'b0, rsp_err}, 32'd1);
        step();
        drive_in(1'b0, 32'h0, 1'b0);
        #1 chk("t6_back_idle", {31'b0, req_ready}, 32'd1);

        // reset during a stalled LEN flit
        req_valid = 1'b1; req_dest = 5'd5; req_addr = 32'h7000; req_len = 5'd4; noc_out_ready = 1'b1;
        step(); req_valid = 1'b0;
        step();
        step(); noc_out_ready = 1'b0;
        #1 chk("t7_len", noc_out_flit, 32'd4);
        step();
        #1 chk("t7_len_held", noc_out_flit, 32'd4);
        #2 rst_n = 1'b0;
        #1 chk("t7_rst_valid", {31'b0, noc_out_valid}, 32'd0);
        chk("t7_rst_flit", noc_out_flit, 32'd0);
        chk("t7_rst_last", {31'b0, noc_out_last}, 32'd0);
        chk("t7_rst_req_ready", {31'b0, req_ready}, 32'd0);
        step(); rst_n = 1'b1; noc_out_ready = 1'b1;
        #1 chk("t7_rel_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_dest = 5'd9; req_addr = 32'h8000; req_len = 5'd1;
        step(); req_valid = 1'b0;
        #1 chk("t7_fresh_hdr", noc_out_flit, 32'h4A18_0000);
        chk("t7_fresh_valid", {31'b0, noc_out_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
